// File: rtl/game_tick_gen_pkg.sv
// Shared types and defaults for the game tick generator: FSM state encoding,
// default period constants and the clamped level-to-period arithmetic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [31:0] DEF_BASE_PERIOD = 32'd25_000_000;
    localparam logic [31:0] DEF_STEP        = 32'd2_000_000;
    localparam logic [31:0] DEF_MIN_PERIOD  = 32'd5_000_000;
    localparam logic [3:0]  DEF_MAX_LEVEL   = 4'd9;

    // The product is widened so a large STEP cannot wrap before the clamp is applied.
    function automatic logic [31:0] calcPeriod(
        input logic [31:0] basePeriod,
        input logic [31:0] step,
        input logic [31:0] minPeriod,
        input logic [3:0]  lvl
    );
        logic [35:0] w_prod;
        w_prod = {32'd0, lvl} * {4'd0, step};
        if (basePeriod <= minPeriod) begin
            calcPeriod = minPeriod;
        end else if (w_prod >= {4'd0, basePeriod - minPeriod}) begin
            calcPeriod = minPeriod;
        end else begin
            calcPeriod = basePeriod - w_prod[31:0];
        end
    endfunction

endpackage

// File: rtl/game_tick_gen_if.sv
// Control/status bundle between the game logic and the tick generator.
interface game_tick_gen_if;

    logic       start;
    logic       gameover;
    logic       levelup;
    logic       EN;
    logic [3:0] level;
    logic       running;
    logic       over;

    modport master (
        output start,
        output gameover,
        output levelup,
        input  EN,
        input  level,
        input  running,
        input  over
    );

    modport slave (
        input  start,
        input  gameover,
        input  levelup,
        output EN,
        output level,
        output running,
        output over
    );

endinterface

// File: rtl/game_tick_gen_prescaler.sv
// Loadable 32-bit cycle counter: counts 0..period-1 while enabled and flags the
// terminal count; a load replaces the period used from the following cycle.
module tick_prescaler #(
    parameter logic [31:0] RESET_PERIOD = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_load,
    input  logic [31:0] i_loadPeriod,
    output logic        o_tc
);

    logic [31:0] r_count;
    logic [31:0] r_period;
    logic        w_atTerminal;

    assign w_atTerminal = (r_count == (r_period - 32'd1));
    assign o_tc         = i_enable & w_atTerminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 32'd0;
            r_period <= RESET_PERIOD;
        end else begin
            if (i_clear) begin
                r_count <= 32'd0;
            end else if (i_enable) begin
                r_count <= w_atTerminal ? 32'd0 : r_count + 32'd1;
            end
            if (i_load) begin
                r_period <= i_loadPeriod;
            end
        end
    end

endmodule

// File: rtl/game_tick_gen.sv
// Game tick generator: IDLE/RUN/OVER control FSM, difficulty level register and
// the per-level tick period that drives the score counter's EN input.
module game_tick_gen
    import game_pkg::*;
#(
    parameter logic [31:0] BASE_PERIOD = DEF_BASE_PERIOD,
    parameter logic [31:0] STEP        = DEF_STEP,
    parameter logic [31:0] MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter logic [3:0]  MAX_LEVEL   = DEF_MAX_LEVEL
) (
    input  logic           clk,
    input  logic           rst,
    game_tick_gen_if.slave bus
);

    game_state_t r_state;
    logic [3:0]  r_level;
    logic        r_en;
    logic        r_running;
    logic        r_over;

    logic        w_accept;
    logic        w_run;
    logic        w_tc;
    logic        w_load;
    logic [3:0]  w_levelNext;
    logic [31:0] w_nextPeriod;
    logic [31:0] w_loadPeriod;

    // gameover freezes the counter and suppresses both the tick and any levelup.
    assign w_run       = (r_state == RUN) && !bus.gameover;
    assign w_accept    = (r_state != RUN) && bus.start && !bus.gameover;
    assign w_levelNext = (w_run && bus.levelup && (r_level < MAX_LEVEL)) ? r_level + 4'd1 : r_level;

    // The reload sees the level after a same-cycle levelup.
    assign w_nextPeriod = calcPeriod(BASE_PERIOD, STEP, MIN_PERIOD, w_levelNext);
    assign w_load       = w_accept | w_tc;
    assign w_loadPeriod = w_accept ? BASE_PERIOD : w_nextPeriod;

    tick_prescaler #(
        .RESET_PERIOD(BASE_PERIOD)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_enable    (w_run),
        .i_load      (w_load),
        .i_loadPeriod(w_loadPeriod),
        .o_tc        (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_level   <= 4'd0;
            r_en      <= 1'b0;
            r_running <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, OVER: begin
                    r_en <= 1'b0;
                    if (w_accept) begin
                        r_state   <= RUN;
                        r_level   <= 4'd0;
                        r_running <= 1'b1;
                        r_over    <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.gameover) begin
                        r_state   <= OVER;
                        r_en      <= 1'b0;
                        r_running <= 1'b0;
                        r_over    <= 1'b1;
                    end else begin
                        r_en    <= w_tc;
                        r_level <= w_levelNext;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_en      <= 1'b0;
                    r_running <= 1'b0;
                    r_over    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EN      = r_en;
    assign bus.level   = r_level;
    assign bus.running = r_running;
    assign bus.over    = r_over;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen with BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, MAX_LEVEL=4:
// a countdown model checked every cycle plus directed hand-computed expectations.
module tb_game_tick_gen;

    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINP = 4;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;

    game_tick_gen_if bus();

    game_tick_gen #(
        .BASE_PERIOD(32'd10),
        .STEP       (32'd2),
        .MIN_PERIOD (32'd4),
        .MAX_LEVEL  (4'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic g, input logic l);
        bus.start    = s;
        bus.gameover = g;
        bus.levelup  = l;
    endtask

    // Mode 0/1/2 = idle/run/over; mRemain counts edges left until the next tick.
    int mMode   = 0;
    int mLevel  = 0;
    int mRemain = 0;
    bit mEn     = 1'b0;
    bit modelValid = 1'b0;

    always @(posedge clk) begin : modelStep
        int nMode;
        int nLevel;
        int nRemain;
        bit nEn;
        nMode   = mMode;
        nLevel  = mLevel;
        nRemain = mRemain;
        nEn     = 1'b0;
        if (rst) begin
            nMode   = 0;
            nLevel  = 0;
            nRemain = 0;
            modelValid <= 1'b1;
        end else if (mMode != 1) begin
            if (bus.start && !bus.gameover) begin
                nMode   = 1;
                nLevel  = 0;
                nRemain = BASE;
            end
        end else if (bus.gameover) begin
            nMode = 2;
        end else begin
            if (bus.levelup && nLevel < MAXL) nLevel = nLevel + 1;
            nRemain = nRemain - 1;
            if (nRemain == 0) begin
                nEn     = 1'b1;
                nRemain = BASE - nLevel * STEP;
                if (nRemain < MINP) nRemain = MINP;
            end
        end
        mMode   <= nMode;
        mLevel  <= nLevel;
        mRemain <= nRemain;
        mEn     <= nEn;
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model.EN",      int'(bus.EN),      int'(mEn));
            checkOutput("model.level",   int'(bus.level),   mLevel);
            checkOutput("model.running", int'(bus.running), int'(mMode == 1));
            checkOutput("model.over",    int'(bus.over),    int'(mMode == 2));
        end
    end

    task automatic waitEn(input int maxCycles, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (bus.EN) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(name, int'(found), 1);
    endtask

    task automatic pulseStart(output int k);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        k = cyc;
    endtask

    initial begin : mainSeq
        int k;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.EN",      int'(bus.EN),      0);
        checkOutput("reset.level",   int'(bus.level),   0);
        checkOutput("reset.running", int'(bus.running), 0);
        checkOutput("reset.over",    int'(bus.over),    0);
        rst = 1'b0;

        // levelup and start+gameover in IDLE must both be ignored
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle.level",   int'(bus.level),   0);
        checkOutput("idle.running", int'(bus.running), 0);

        // first game: ticks at k+10, k+20, k+30; a start inside RUN changes nothing
        pulseStart(k);
        checkOutput("A.running", int'(bus.running), 1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            checkOutput("A.EN", int'(bus.EN), int'((i % 10) == 0));
            if (i == 14) applyStimulus(1'b1, 1'b0, 1'b0);
            else if (i == 15) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("A.level",   int'(bus.level),   0);
        checkOutput("A.running", int'(bus.running), 1);

        // levelup mid-period: current period untouched, next one is 8
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulseStart(k);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            checkOutput("B.EN", int'(bus.EN), int'(i == 10 || i == 18));
            if (i == 5) begin
                checkOutput("B.levelBefore", int'(bus.level), 0);
                applyStimulus(1'b0, 1'b0, 1'b1);
            end else if (i == 6) begin
                checkOutput("B.levelAfter", int'(bus.level), 1);
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
        end

        // six levelups saturate at 4; period clamps to MIN_PERIOD=4
        for (int p = 0; p < 6; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        checkOutput("C.levelSat", int'(bus.level), 4);
        waitEn(20, "C.findEN");
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                checkOutput("C.spacing", int'(bus.EN), int'(i == 4));
            end
        end

        // gameover lands on the terminal-count edge: no tick, game ends
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("D.EN",      int'(bus.EN),      0);
        checkOutput("D.over",    int'(bus.over),    1);
        checkOutput("D.running", int'(bus.running), 0);
        checkOutput("D.level",   int'(bus.level),   4);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("D.overHeld",  int'(bus.over),  1);
        checkOutput("D.levelHeld", int'(bus.level), 4);

        // restart from OVER, then reset right where the second tick would fire
        pulseStart(k);
        checkOutput("E.levelCleared", int'(bus.level), 0);
        checkOutput("E.running",      int'(bus.running), 1);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            checkOutput("E.EN", int'(bus.EN), int'(i == 10));
            if (i == 2) applyStimulus(1'b0, 1'b0, 1'b1);
            else if (i == 3) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("E.levelBeforeRst", int'(bus.level), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("E.rstEN",      int'(bus.EN),      0);
        checkOutput("E.rstLevel",   int'(bus.level),   0);
        checkOutput("E.rstRunning", int'(bus.running), 0);
        checkOutput("E.rstOver",    int'(bus.over),    0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("E.postRstEN", int'(bus.EN), 0);
        @(negedge clk);
        checkOutput("E.postRstEN2",  int'(bus.EN),      0);
        checkOutput("E.postRstIdle", int'(bus.running), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/game_tick_gen.md
GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 Parameter BASE_PERIOD, default 25_000_000; tick period in clk cycles at level 0.
REQ-002 Parameter STEP, default 2_000_000; period reduction per level.
REQ-003 Parameter MIN_PERIOD, default 5_000_000; floor on tick period, must be >= 2.
REQ-004 Parameter MAX_LEVEL, default 9; level saturation value, must be <= 15.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a game.
REQ-008 gameover  in  1  level signal from game logic; ends the current game.
REQ-009 levelup  in  1  single-cycle pulse from the score counter.
REQ-010 EN  out  1  single-cycle game tick; drives the score counter's EN input.
REQ-011 level  out  4  current difficulty level.
REQ-012 running  out  1  high while in RUN.
REQ-013 over  out  1  high while in OVER.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and OVER.
REQ-015 IDLE: when start=1 and gameover=0, go to RUN, clear level and the cycle counter, and load period_q=BASE_PERIOD.
REQ-016 RUN: the cycle counter SHALL increment every cycle.
REQ-017 RUN: when counter==period_q-1, EN=1 for that cycle, the counter returns to 0, and period_q is reloaded with max(BASE_PERIOD-level*STEP, MIN_PERIOD), using the level value after any same-cycle levelup.
REQ-018 Therefore the first EN SHALL occur BASE_PERIOD cycles after the edge that accepted start, and EN SHALL repeat every period_q cycles after that.
REQ-019 RUN: levelup=1 SHALL increment level, saturating at MAX_LEVEL; the period currently running is not shortened, and the new period applies from the next reload.
REQ-020 RUN: gameover=1 SHALL move to OVER on that edge; EN SHALL be 0 in that cycle even if the counter is at terminal count; a simultaneous levelup is ignored.
REQ-021 OVER: EN=0 and the counter is held; level is held for display.
REQ-022 OVER: start=1 and gameover=0 SHALL behave as REQ-015 (level returns to 0).
REQ-023 start in RUN, and gameover or levelup in IDLE/OVER, SHALL be ignored.
REQ-024 If start and gameover are both 1 in IDLE/OVER, gameover wins and the state is unchanged.
REQ-025 EN SHALL be registered, and never high for two consecutive cycles (MIN_PERIOD>=2).
REQ-026 Period arithmetic SHALL use 32-bit unsigned values; the subtraction is clamped so it never wraps (if level*STEP >= BASE_PERIOD-MIN_PERIOD, the result is MIN_PERIOD).

Reset
REQ-027 rst=1 SHALL override all inputs; after the edge: state=IDLE, counter=0, period_q=BASE_PERIOD, level=0, EN=0, running=0, over=0.
REQ-028 rst asserted mid-RUN SHALL abort the game with no EN pulse in the reset cycle or the following cycle.

Structure
REQ-029 Shared package game_pkg SHALL hold the state enum (IDLE/RUN/OVER) and the default period constants.
REQ-030 Sub-module tick_prescaler SHALL be used: a loadable 32-bit counter with clear, enable and terminal-count pulse output.
REQ-031 The FSM, level register and period computation SHALL reside in game_tick_gen.

Verification (BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, MAX_LEVEL=4)
REQ-032 rst, then start at edge k -> EN high exactly at cycles k+10, k+20, k+30; running=1; level=0.
REQ-033 levelup at k+5 -> level=1 at k+6; EN still at k+10; next EN at k+18.
REQ-034 Six levelup pulses in RUN -> level saturates at 4; period clamps to 4 (10-8=2 <4); EN spacing is 4 cycles.
REQ-035 gameover asserted in the terminal-count cycle -> no EN, over=1, running=0, level held; later levelup/start+gameover has no effect.
REQ-036 start in OVER -> level=0, first EN 10 cycles later; rst mid-RUN -> all outputs 0 next cycle, no EN for 2 cycles.
